m_connect4_game_ctrl: RTL
=========================

# m_connect4_game_ctrl

Game-state controller for the 7x6 connect-four engine. It owns the board: it accepts validated human moves and launches the depth-first game-tree search with the board from the AI's point of view. It applies the column the search returns and detects win and draw after every move. It sits directly upstream of `m_depth_first_game_tree`, driving its `i_en` and board inputs, and directly downstream of it, consuming its `o_fin` and `o_col`.

## Interface
Parameters:
- `MAX_PIECES`, 42, board capacity; a draw is declared when the piece count reaches it with no win.

Ports:
- `w_clk` in 1: system clock.
- `w_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_start` in 1: new-game pulse; honoured in every state.
- `i_human_first` in 1: sampled with `i_start`; 1 means human moves first.
- `i_mv_valid` in 1: human move request.
- `i_mv_col` in `COL_SIZE`: requested column, 0..6.
- `o_mv_ready` out 1: controller is waiting for a human move.
- `o_err_illegal` out 1: one-cycle pulse when a human move is rejected.
- `o_srch_en` out 1: drives the search engine's `i_en`.
- `o_me_field` out `FIELD_SIZE`: AI pieces (search "me").
- `o_op_field` out `FIELD_SIZE`: human pieces (search "op").
- `o_pile_count_array` out `PILE_COUNT_ARRAY_SIZE`: pile height per column.
- `i_srch_fin` in 1: search done.
- `i_srch_col` in `COL_SIZE`: chosen column.
- `i_srch_score` in 16 signed: search score.
- `o_last_score` out 16 signed: score of the last applied AI move.
- `o_result` out 2: game result. 00 = none, 01 = human win, 10 = AI win, 11 = draw.
- `o_piece_cnt` out 6: number of pieces on the board.

## Operation
- Board layout:
  - Field bit index = row*7 + col, with row 0 at the bottom.
  - The pile for column c sits at `[3c+2:3c]` of the pile array.
  - Dropping into column c sets field bit `pile[c]*7 + c` and increments `pile[c]`.
- States: IDLE, CLEAR, H_WAIT, H_CHECK, AI_SEARCH, AI_CHECK, OVER.
- IDLE: after reset. The controller waits for `i_start`.
- `i_start`, from any state: go to CLEAR. This overrides every other event in the same cycle.
- CLEAR: lasts one cycle.
  - Zero both fields, all piles, `o_piece_cnt` and `o_result`.
  - Go to H_WAIT if the latched `i_human_first` is 1, otherwise go to AI_SEARCH.
- H_WAIT: `o_mv_ready` = 1. When `i_mv_valid` is high:
  - Illegal move (`i_mv_col` > 6, or `pile[col]` == 6): pulse `o_err_illegal` for one cycle and stay in H_WAIT. The board is unchanged.
  - Legal move: drop a human piece at this edge, increment `o_piece_cnt`, go to H_CHECK.
- H_CHECK: evaluate a four-in-a-row on `o_op_field`, covering horizontal, vertical and both diagonals (69 lines).
  - Win: `o_result` = 01, go to OVER.
  - Else, if `o_piece_cnt` == `MAX_PIECES`: `o_result` = 11, go to OVER.
  - Else: go to AI_SEARCH.
- AI_SEARCH:
  - `o_srch_en` = 1 for the whole state.
  - Fields and piles are held stable while `o_srch_en` is high.
  - On `i_srch_fin` = 1: drop an AI piece in `i_srch_col`, capture `i_srch_score` into `o_last_score`, and go to AI_CHECK.
  - If `i_srch_col` is illegal (> 6 or full), use the lowest-indexed non-full column instead.
- AI_CHECK: same checks as H_CHECK, run on `o_me_field`.
  - Win gives `o_result` = 10; a full board gives 11.
  - Either case goes to OVER; otherwise go to H_WAIT.
- OVER: hold the board and `o_result`. Only `i_start` leaves this state.

## Timing
- Reset values:
  - State IDLE.
  - All fields, piles, `o_piece_cnt`, `o_result` and `o_last_score` = 0.
  - `o_mv_ready`, `o_err_illegal` and `o_srch_en` = 0.
- Human move, handshake at edge t:
  - The board is updated at t.
  - H_CHECK occupies cycle t+1.
  - `o_srch_en` rises at t+2 if the game continues.
- AI move:
  - `i_srch_fin` sampled high at edge t: the board is updated and `o_srch_en` = 0 from t.
  - AI_CHECK occupies cycle t+1.
  - `o_mv_ready` = 1 at t+2.
- `o_srch_en` is low for at least one cycle between two searches, so the engine restarts. Two searches are always separated by H_WAIT; `i_start` goes through CLEAR.
- `i_srch_fin` is ignored outside AI_SEARCH. `i_mv_valid` is ignored outside H_WAIT.
- `i_start` during AI_SEARCH: `o_srch_en` is 0 from the next cycle. A `i_srch_fin` arriving in that same cycle is discarded.
- All outputs are registered; none has a combinational path from an input.

## Test plan
- Reset, then `i_start` with `i_human_first` = 1:
  - CLEAR for one cycle, then `o_mv_ready` = 1.
  - Fields = 0, `o_result` = 00.
- Human plays column 3:
  - `o_op_field` bit 3 set, pile bits [11:9] = 1.
  - `o_srch_en` rises 2 cycles after the handshake.
  - The model returns col 2 with score 5. Result: `o_me_field` bit 2 set, `o_last_score` = 5, `o_mv_ready` = 1 two cycles after fin.
- Fill column 0 to six pieces, then play human col 0:
  - One-cycle `o_err_illegal`, board unchanged, still H_WAIT.
  - Col 7 also raises `o_err_illegal`.
- Human plays col 4 four times while the model answers col 0:
  - After the 4th human move, `o_result` = 01 and the state goes to OVER.
  - `o_srch_en` never rises again; further `i_mv_valid` has no effect.
- AI first:
  - The model builds a diagonal (0,1,2,3 at rising heights).
  - `o_result` = 10 one cycle after the winning fin.
- Full-column fallback and restart:
  - The model returns a full column 0; the AI piece lands in column 1.
  - `i_start` mid-AI_SEARCH: `o_srch_en` = 0 the next cycle, board cleared, `o_piece_cnt` = 0.

Source files
------------

// File: rtl/m_connect4_game_ctrl.sv
// Connect-four game-state controller: owns the 7x6 board, takes human moves,
// runs the AI search handshake and detects win/draw after every move.
module m_connect4_game_ctrl #(
  parameter int MAX_PIECES = 42,
  localparam int COL_SIZE = 3,
  localparam int FIELD_SIZE = 42,
  localparam int PILE_COUNT_ARRAY_SIZE = 21
) (
  input  logic                             w_clk,
  input  logic                             w_rst_n,
  input  logic                             i_start,
  input  logic                             i_human_first,
  input  logic                             i_mv_valid,
  input  logic [COL_SIZE-1:0]              i_mv_col,
  output logic                             o_mv_ready,
  output logic                             o_err_illegal,
  output logic                             o_srch_en,
  output logic [FIELD_SIZE-1:0]            o_me_field,
  output logic [FIELD_SIZE-1:0]            o_op_field,
  output logic [PILE_COUNT_ARRAY_SIZE-1:0] o_pile_count_array,
  input  logic                             i_srch_fin,
  input  logic [COL_SIZE-1:0]              i_srch_col,
  input  logic signed [15:0]               i_srch_score,
  output logic signed [15:0]               o_last_score,
  output logic [1:0]                       o_result,
  output logic [5:0]                       o_piece_cnt,
  output logic [2:0]                       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_H_WAIT    = 3'd2,
    S_H_CHECK   = 3'd3,
    S_AI_SEARCH = 3'd4,
    S_AI_CHECK  = 3'd5,
    S_OVER      = 3'd6
  } state_t;

  state_t                           state_q, state_d;
  logic [FIELD_SIZE-1:0]            me_q, me_d, op_q, op_d;
  logic [PILE_COUNT_ARRAY_SIZE-1:0] pile_q, pile_d;
  logic [5:0]                       cnt_q, cnt_d;
  logic [1:0]                       result_q, result_d;
  logic signed [15:0]               score_q, score_d;
  logic                             hf_q, hf_d;
  logic                             err_q, err_d;
  logic                             mv_ready_q, srch_en_q;
  logic                             mv_illegal;
  logic [COL_SIZE-1:0]              ai_col;

  // Column 7 reports a full pile so one comparison covers both illegal cases.
  function automatic logic [2:0] pile_of(input logic [20:0] arr, input logic [2:0] col);
    logic [2:0] h;
    h = 3'd6;
    for (int c = 0; c < 7; c++)
      if (col == 3'(c)) h = arr[3*c +: 3];
    return h;
  endfunction

  function automatic logic [2:0] first_open(input logic [20:0] arr);
    logic [2:0] col;
    logic       found;
    col   = 3'd0;
    found = 1'b0;
    for (int c = 0; c < 7; c++)
      if (!found && arr[3*c +: 3] != 3'd6) begin
        col   = 3'(c);
        found = 1'b1;
      end
    return col;
  endfunction

  function automatic logic [41:0] drop_field(input logic [41:0] f, input logic [20:0] arr,
                                             input logic [2:0] col);
    logic [41:0] r_f;
    r_f = f;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        if (col == 3'(c) && arr[3*c +: 3] == 3'(r)) r_f[r*7+c] = 1'b1;
    return r_f;
  endfunction

  function automatic logic [20:0] bump_pile(input logic [20:0] arr, input logic [2:0] col);
    logic [20:0] r_a;
    r_a = arr;
    for (int c = 0; c < 7; c++)
      if (col == 3'(c)) r_a[3*c +: 3] = arr[3*c +: 3] + 3'd1;
    return r_a;
  endfunction

  // 24 horizontal, 21 vertical and 2x12 diagonal lines.
  function automatic logic has_four(input logic [41:0] f);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        if (f[r*7+c] && f[r*7+c+1] && f[r*7+c+2] && f[r*7+c+3]) hit = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 7; c++)
        if (f[r*7+c] && f[r*7+c+7] && f[r*7+c+14] && f[r*7+c+21]) hit = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (f[r*7+c] && f[r*7+c+8] && f[r*7+c+16] && f[r*7+c+24]) hit = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 3; c < 7; c++)
        if (f[r*7+c] && f[r*7+c+6] && f[r*7+c+12] && f[r*7+c+18]) hit = 1'b1;
    return hit;
  endfunction

  assign mv_illegal = (pile_of(pile_q, i_mv_col) == 3'd6);
  assign ai_col     = (pile_of(pile_q, i_srch_col) == 3'd6) ? first_open(pile_q) : i_srch_col;

  always_comb begin
    state_d  = state_q;
    me_d     = me_q;
    op_d     = op_q;
    pile_d   = pile_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    score_d  = score_q;
    hf_d     = hf_q;
    err_d    = 1'b0;
    if (i_start) begin
      state_d  = S_CLEAR;
      me_d     = '0;
      op_d     = '0;
      pile_d   = '0;
      cnt_d    = '0;
      result_d = 2'b00;
      hf_d     = i_human_first;
    end else begin
      case (state_q)
        S_CLEAR: state_d = hf_q ? S_H_WAIT : S_AI_SEARCH;
        S_H_WAIT: begin
          if (i_mv_valid) begin
            if (mv_illegal) begin
              err_d = 1'b1;
            end else begin
              op_d    = drop_field(op_q, pile_q, i_mv_col);
              pile_d  = bump_pile(pile_q, i_mv_col);
              cnt_d   = cnt_q + 6'd1;
              state_d = S_H_CHECK;
            end
          end
        end
        S_H_CHECK: begin
          if (has_four(op_q)) begin
            result_d = 2'b01;
            state_d  = S_OVER;
          end else if (cnt_q == 6'(MAX_PIECES)) begin
            result_d = 2'b11;
            state_d  = S_OVER;
          end else begin
            state_d = S_AI_SEARCH;
          end
        end
        S_AI_SEARCH: begin
          if (i_srch_fin) begin
            me_d    = drop_field(me_q, pile_q, ai_col);
            pile_d  = bump_pile(pile_q, ai_col);
            cnt_d   = cnt_q + 6'd1;
            score_d = i_srch_score;
            state_d = S_AI_CHECK;
          end
        end
        S_AI_CHECK: begin
          if (has_four(me_q)) begin
            result_d = 2'b10;
            state_d  = S_OVER;
          end else if (cnt_q == 6'(MAX_PIECES)) begin
            result_d = 2'b11;
            state_d  = S_OVER;
          end else begin
            state_d = S_H_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs follow the next state so they are valid for the whole state.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_IDLE;
      me_q       <= '0;
      op_q       <= '0;
      pile_q     <= '0;
      cnt_q      <= '0;
      result_q   <= 2'b00;
      score_q    <= '0;
      hf_q       <= 1'b0;
      err_q      <= 1'b0;
      mv_ready_q <= 1'b0;
      srch_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      me_q       <= me_d;
      op_q       <= op_d;
      pile_q     <= pile_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      score_q    <= score_d;
      hf_q       <= hf_d;
      err_q      <= err_d;
      mv_ready_q <= (state_d == S_H_WAIT);
      srch_en_q  <= (state_d == S_AI_SEARCH);
    end
  end

  assign o_mv_ready         = mv_ready_q;
  assign o_err_illegal      = err_q;
  assign o_srch_en          = srch_en_q;
  assign o_me_field         = me_q;
  assign o_op_field         = op_q;
  assign o_pile_count_array = pile_q;
  assign o_last_score       = score_q;
  assign o_result           = result_q;
  assign o_piece_cnt        = cnt_q;
  assign o_dbg_state        = state_q;

endmodule
